// File: rtl/xadac_scoreboard.sv
// Issue scoreboard for the xadac coprocessor: allocates transaction IDs and
// tracks pending scalar/vector destination writes to stall RAW/WAW hazards.
module xadac_scoreboard #(
  parameter int unsigned NoRs         = 2,
  parameter int unsigned NoVs         = 3,
  parameter int unsigned IdWidth      = 4,
  parameter int unsigned RegAddrWidth = 5,
  parameter int unsigned VecAddrWidth = 5
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         issue_valid_i,
  output logic                         issue_ready_o,
  output logic [IdWidth-1:0]           issue_id_o,
  input  logic [NoRs*RegAddrWidth-1:0] issue_rs_addr_i,
  input  logic [NoRs-1:0]              issue_rs_read_i,
  input  logic [NoVs*VecAddrWidth-1:0] issue_vs_addr_i,
  input  logic [NoVs-1:0]              issue_vs_read_i,
  input  logic [RegAddrWidth-1:0]      issue_rd_addr_i,
  input  logic                         issue_rd_clobber_i,
  input  logic [VecAddrWidth-1:0]      issue_vd_addr_i,
  input  logic                         issue_vd_clobber_i,
  input  logic                         rsp_valid_i,
  input  logic [IdWidth-1:0]           rsp_id_i,
  output logic [IdWidth:0]             inflight_o,
  output logic                         idle_o,
  output logic                         spurious_o
);

  localparam int unsigned SbLen    = 2 ** IdWidth;
  localparam int unsigned NumRegs  = 2 ** RegAddrWidth;
  localparam int unsigned NumVregs = 2 ** VecAddrWidth;

  logic [SbLen-1:0]                   valid_q, valid_d;
  logic [SbLen-1:0][RegAddrWidth-1:0] rd_addr_q, rd_addr_d;
  logic [SbLen-1:0]                   rd_pend_q, rd_pend_d;
  logic [SbLen-1:0][VecAddrWidth-1:0] vd_addr_q, vd_addr_d;
  logic [SbLen-1:0]                   vd_pend_q, vd_pend_d;
  logic [NumRegs-1:0]                 reg_pend_q, reg_pend_d;
  logic [NumVregs-1:0]                vec_pend_q, vec_pend_d;
  logic [IdWidth:0]                   inflight_q, inflight_d;
  logic                               spurious_q, spurious_d;

  logic [IdWidth-1:0] free_id;
  logic               full;
  logic               raw;
  logic               waw;
  logic               fire;
  logic               retire;
  logic               new_rd_pend;

  // Descending scan so the last assignment wins: lowest-indexed free entry.
  always_comb begin
    free_id = '0;
    full    = 1'b1;
    for (int i = SbLen - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_id = IdWidth'(i);
        full    = 1'b0;
      end
    end
  end

  always_comb begin
    raw = 1'b0;
    waw = 1'b0;
    for (int i = 0; i < NoRs; i++) begin
      if (issue_rs_read_i[i] &&
          (issue_rs_addr_i[i*RegAddrWidth +: RegAddrWidth] != '0) &&
          reg_pend_q[issue_rs_addr_i[i*RegAddrWidth +: RegAddrWidth]]) begin
        raw = 1'b1;
      end
    end
    for (int j = 0; j < NoVs; j++) begin
      if (issue_vs_read_i[j] &&
          vec_pend_q[issue_vs_addr_i[j*VecAddrWidth +: VecAddrWidth]]) begin
        raw = 1'b1;
      end
    end
    if (issue_rd_clobber_i && (issue_rd_addr_i != '0) && reg_pend_q[issue_rd_addr_i]) begin
      waw = 1'b1;
    end
    if (issue_vd_clobber_i && vec_pend_q[issue_vd_addr_i]) begin
      waw = 1'b1;
    end
  end

  assign issue_ready_o = !full && !raw && !waw;
  assign issue_id_o    = free_id;
  assign fire          = issue_valid_i && issue_ready_o;
  assign retire        = rsp_valid_i && valid_q[rsp_id_i];
  assign new_rd_pend   = issue_rd_clobber_i && (issue_rd_addr_i != '0);

  // Retire clears first; issue never targets a register being cleared
  // because WAW stalls keep at most one pending writer per register.
  always_comb begin
    valid_d    = valid_q;
    rd_addr_d  = rd_addr_q;
    rd_pend_d  = rd_pend_q;
    vd_addr_d  = vd_addr_q;
    vd_pend_d  = vd_pend_q;
    reg_pend_d = reg_pend_q;
    vec_pend_d = vec_pend_q;
    inflight_d = inflight_q;
    spurious_d = rsp_valid_i && !valid_q[rsp_id_i];

    if (retire) begin
      valid_d[rsp_id_i] = 1'b0;
      if (rd_pend_q[rsp_id_i]) begin
        reg_pend_d[rd_addr_q[rsp_id_i]] = 1'b0;
      end
      if (vd_pend_q[rsp_id_i]) begin
        vec_pend_d[vd_addr_q[rsp_id_i]] = 1'b0;
      end
    end

    if (fire) begin
      valid_d[free_id]   = 1'b1;
      rd_addr_d[free_id] = issue_rd_addr_i;
      rd_pend_d[free_id] = new_rd_pend;
      vd_addr_d[free_id] = issue_vd_addr_i;
      vd_pend_d[free_id] = issue_vd_clobber_i;
      if (new_rd_pend) begin
        reg_pend_d[issue_rd_addr_i] = 1'b1;
      end
      if (issue_vd_clobber_i) begin
        vec_pend_d[issue_vd_addr_i] = 1'b1;
      end
    end

    case ({fire, retire})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q    <= '0;
      rd_addr_q  <= '0;
      rd_pend_q  <= '0;
      vd_addr_q  <= '0;
      vd_pend_q  <= '0;
      reg_pend_q <= '0;
      vec_pend_q <= '0;
      inflight_q <= '0;
      spurious_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      rd_addr_q  <= rd_addr_d;
      rd_pend_q  <= rd_pend_d;
      vd_addr_q  <= vd_addr_d;
      vd_pend_q  <= vd_pend_d;
      reg_pend_q <= reg_pend_d;
      vec_pend_q <= vec_pend_d;
      inflight_q <= inflight_d;
      spurious_q <= spurious_d;
    end
  end

  assign inflight_o = inflight_q;
  assign idle_o     = (inflight_q == '0);
  assign spurious_o = spurious_q;

endmodule

// File: tb/tb_xadac_scoreboard.sv
// Scoreboard bench for xadac_scoreboard: a per-instruction reference model
// predicts each cycle's outputs, a monitor pops and compares at negedge.
module tb_xadac_scoreboard;

  logic        clk_i;
  logic        rst_i;
  logic        issue_valid_i;
  logic        issue_ready_o;
  logic [3:0]  issue_id_o;
  logic [9:0]  issue_rs_addr_i;
  logic [1:0]  issue_rs_read_i;
  logic [14:0] issue_vs_addr_i;
  logic [2:0]  issue_vs_read_i;
  logic [4:0]  issue_rd_addr_i;
  logic        issue_rd_clobber_i;
  logic [4:0]  issue_vd_addr_i;
  logic        issue_vd_clobber_i;
  logic        rsp_valid_i;
  logic [3:0]  rsp_id_i;
  logic [4:0]  inflight_o;
  logic        idle_o;
  logic        spurious_o;

  xadac_scoreboard dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .issue_valid_i      (issue_valid_i),
    .issue_ready_o      (issue_ready_o),
    .issue_id_o         (issue_id_o),
    .issue_rs_addr_i    (issue_rs_addr_i),
    .issue_rs_read_i    (issue_rs_read_i),
    .issue_vs_addr_i    (issue_vs_addr_i),
    .issue_vs_read_i    (issue_vs_read_i),
    .issue_rd_addr_i    (issue_rd_addr_i),
    .issue_rd_clobber_i (issue_rd_clobber_i),
    .issue_vd_addr_i    (issue_vd_addr_i),
    .issue_vd_clobber_i (issue_vd_clobber_i),
    .rsp_valid_i        (rsp_valid_i),
    .rsp_id_i           (rsp_id_i),
    .inflight_o         (inflight_o),
    .idle_o             (idle_o),
    .spurious_o         (spurious_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef struct packed {
    logic            iv;
    logic [1:0][4:0] rs;
    logic [1:0]      rsr;
    logic [2:0][4:0] vs;
    logic [2:0]      vsr;
    logic [4:0]      rd;
    logic            rdc;
    logic [4:0]      vd;
    logic            vdc;
    logic            rv;
    logic [3:0]      rid;
  } stim_t;

  typedef struct {
    bit         ready;
    bit         chk_id;
    logic [3:0] id;
    int         inflight;
    bit         idle;
    bit         spur;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: one record per in-flight instruction, indexed by ID.
  bit         m_valid[16];
  logic [4:0] m_rd[16];
  bit         m_rdw[16];
  logic [4:0] m_vd[16];
  bit         m_vdw[16];
  int         m_count;
  bit         m_spur;

  // Effects of the most recently driven cycle, applied at the next edge.
  bit         p_fire, p_ret, p_spur, p_rdw, p_vdw;
  logic [3:0] p_id, p_rid;
  logic [4:0] p_rd, p_vd;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int e = 0; e < 16; e++) begin
      m_valid[e] = 0;
      m_rdw[e]   = 0;
      m_vdw[e]   = 0;
    end
    m_count = 0;
    m_spur  = 0;
    p_fire  = 0;
    p_ret   = 0;
    p_spur  = 0;
  endtask

  task automatic model_commit();
    if (p_ret) begin
      m_valid[p_rid] = 0;
      m_count--;
    end
    if (p_fire) begin
      m_valid[p_id] = 1;
      m_rd[p_id]    = p_rd;
      m_rdw[p_id]   = p_rdw;
      m_vd[p_id]    = p_vd;
      m_vdw[p_id]   = p_vdw;
      m_count++;
    end
    m_spur = p_spur;
  endtask

  function automatic stim_t idle_stim();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    int    live[$];
    s.iv  = ($urandom_range(0, 3) != 0);
    for (int i = 0; i < 2; i++) s.rs[i] = 5'($urandom_range(0, 7));
    for (int j = 0; j < 3; j++) s.vs[j] = 5'($urandom_range(0, 7));
    s.rsr = 2'($urandom);
    s.vsr = 3'($urandom);
    s.rd  = 5'($urandom_range(0, 7));
    s.rdc = 1'($urandom);
    s.vd  = 5'($urandom_range(0, 7));
    s.vdc = 1'($urandom);
    s.rv  = ($urandom_range(0, 9) < 4);
    for (int e = 0; e < 16; e++) if (m_valid[e]) live.push_back(e);
    if (live.size() > 0 && $urandom_range(0, 9) < 8)
      s.rid = 4'(live[$urandom_range(0, live.size() - 1)]);
    else
      s.rid = 4'($urandom);
    return s;
  endfunction

  task automatic drive(input stim_t s);
    issue_valid_i      = s.iv;
    issue_rs_addr_i    = s.rs;
    issue_rs_read_i    = s.rsr;
    issue_vs_addr_i    = s.vs;
    issue_vs_read_i    = s.vsr;
    issue_rd_addr_i    = s.rd;
    issue_rd_clobber_i = s.rdc;
    issue_vd_addr_i    = s.vd;
    issue_vd_clobber_i = s.vdc;
    rsp_valid_i        = s.rv;
    rsp_id_i           = s.rid;
  endtask

  // One clock: update the model for the edge, drive new inputs, predict.
  task automatic apply_stimulus(input stim_t s);
    exp_t       x;
    bit         raw, waw, full, found;
    logic [3:0] free;
    @(posedge clk_i);
    model_commit();
    #1;
    drive(s);
    raw   = 0;
    waw   = 0;
    full  = (m_count == 16);
    found = 0;
    free  = '0;
    for (int e = 0; e < 16; e++) begin
      if (!m_valid[e] && !found) begin
        free  = 4'(e);
        found = 1;
      end
      if (m_valid[e]) begin
        for (int i = 0; i < 2; i++)
          if (s.rsr[i] && s.rs[i] != 0 && m_rdw[e] && m_rd[e] == s.rs[i]) raw = 1;
        for (int j = 0; j < 3; j++)
          if (s.vsr[j] && m_vdw[e] && m_vd[e] == s.vs[j]) raw = 1;
        if (s.rdc && s.rd != 0 && m_rdw[e] && m_rd[e] == s.rd) waw = 1;
        if (s.vdc && m_vdw[e] && m_vd[e] == s.vd) waw = 1;
      end
    end
    x.ready    = !full && !raw && !waw;
    x.chk_id   = x.ready;
    x.id       = free;
    x.inflight = m_count;
    x.idle     = (m_count == 0);
    x.spur     = m_spur;
    exp_q.push_back(x);
    p_fire = s.iv && x.ready;
    p_id   = free;
    p_rd   = s.rd;
    p_rdw  = s.rdc && (s.rd != 0);
    p_vd   = s.vd;
    p_vdw  = s.vdc;
    p_ret  = s.rv && m_valid[s.rid];
    p_rid  = s.rid;
    p_spur = s.rv && !m_valid[s.rid];
  endtask

  initial begin
    exp_t x;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check_output("issue_ready", 32'(issue_ready_o), 32'(x.ready));
        if (x.chk_id) check_output("issue_id", 32'(issue_id_o), 32'(x.id));
        check_output("inflight", 32'(inflight_o), 32'(x.inflight));
        check_output("idle", 32'(idle_o), 32'(x.idle));
        check_output("spurious", 32'(spurious_o), 32'(x.spur));
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check_output({tag, "_inflight"}, 32'(inflight_o), 32'd0);
    check_output({tag, "_idle"}, 32'(idle_o), 32'd1);
    check_output({tag, "_spurious"}, 32'(spurious_o), 32'd0);
    check_output({tag, "_ready"}, 32'(issue_ready_o), 32'd1);
  endtask

  // Asynchronous reset in the middle of a cycle; the current (possibly
  // hazardous) inputs stay applied while the cleared state is checked.
  task automatic mid_reset();
    @(posedge clk_i);
    model_commit();
    #3 rst_i = 1'b1;
    #1 check_reset_state("async_rst");
    drive(idle_stim());
    model_clear();
    @(posedge clk_i);
    #3 rst_i = 1'b0;
  endtask

  initial begin
    stim_t s;
    rst_i = 1'b1;
    drive(idle_stim());
    model_clear();
    #12 check_reset_state("por");
    @(posedge clk_i);
    #3 rst_i = 1'b0;

    // x5 writer, then a reader of x5 stalls until the writer retires.
    s = idle_stim(); s.iv = 1; s.rd = 5; s.rdc = 1;
    apply_stimulus(s);
    s = idle_stim(); s.iv = 1; s.rs[0] = 5; s.rsr = 2'b01;
    apply_stimulus(s);
    s.rv = 1; s.rid = 0;
    apply_stimulus(s);
    s.rv = 0;
    apply_stimulus(s);
    apply_stimulus(s);
    mid_reset();

    // Vector WAW on v3 stalls; an independent op takes ID 1.
    s = idle_stim(); s.iv = 1; s.vd = 3; s.vdc = 1;
    apply_stimulus(s);
    apply_stimulus(s);
    s = idle_stim(); s.iv = 1; s.vs[2] = 4; s.vsr = 3'b100; s.vd = 7; s.vdc = 1;
    apply_stimulus(s);
    // x0 is never tracked; unallocated ID 12 is spurious.
    s = idle_stim(); s.iv = 1; s.rd = 0; s.rdc = 1; s.rsr = 2'b11;
    apply_stimulus(s);
    apply_stimulus(s);
    s = idle_stim(); s.rv = 1; s.rid = 12;
    apply_stimulus(s);
    s = idle_stim();
    apply_stimulus(s);
    apply_stimulus(s);
    mid_reset();

    // Issue ID 2 in the same cycle ID 0 retires.
    s = idle_stim(); s.iv = 1;
    apply_stimulus(s);
    apply_stimulus(s);
    s.rv = 1; s.rid = 0;
    apply_stimulus(s);
    s = idle_stim();
    apply_stimulus(s);
    mid_reset();

    // Fill all 16 IDs, stall on full, retire ID 9 and reuse it.
    s = idle_stim(); s.iv = 1;
    for (int k = 0; k < 17; k++) apply_stimulus(s);
    s.rv = 1; s.rid = 9;
    apply_stimulus(s);
    s.rv = 0;
    apply_stimulus(s);
    apply_stimulus(s);

    for (int k = 0; k < 1500; k++) begin
      apply_stimulus(rand_stim());
      if (k == 700) begin
        mid_reset();
        s = idle_stim(); s.rv = 1; s.rid = 4'($urandom);
        apply_stimulus(s);
      end
    end
    apply_stimulus(idle_stim());

    @(negedge clk_i);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xadac_scoreboard.md
Name: xadac_scoreboard

Overview:
- Issue controller between the xadac decode stage and the execute unit.
- Allocates transaction IDs and tracks pending scalar (rd) and vector (vd) destination writes for in-flight instructions.
- Stalls issue on RAW/WAW hazards or when all IDs are in use.
- Releases IDs and pending bits when the execute response retires.

Parameters:
- NoRs, 2, scalar source operands per instruction
- NoVs, 3, vector source operands per instruction
- IdWidth, 4, transaction ID width; SbLen = 2**IdWidth entries
- RegAddrWidth, 5, scalar register address width (32 regs)
- VecAddrWidth, 5, vector register address width (32 vregs)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- issue_valid_i  in  1  decoded instruction offered for issue
- issue_ready_o  out  1  issue accepted this cycle when issue_valid_i is also high
- issue_id_o  out  IdWidth  ID allocated to the instruction; valid while issue_valid_i && issue_ready_o
- issue_rs_addr_i  in  NoRs*RegAddrWidth  scalar source addresses
- issue_rs_read_i  in  NoRs  per-source scalar read enable
- issue_vs_addr_i  in  NoVs*VecAddrWidth  vector source addresses
- issue_vs_read_i  in  NoVs  per-source vector read enable
- issue_rd_addr_i  in  RegAddrWidth  scalar destination
- issue_rd_clobber_i  in  1  instruction writes the scalar destination
- issue_vd_addr_i  in  VecAddrWidth  vector destination
- issue_vd_clobber_i  in  1  instruction writes the vector destination
- rsp_valid_i  in  1  execute response retiring an ID (always accepted; no ready)
- rsp_id_i  in  IdWidth  ID being retired
- inflight_o  out  IdWidth+1  number of allocated IDs
- idle_o  out  1  no IDs allocated
- spurious_o  out  1  one-cycle pulse: rsp_valid_i carried an unallocated ID

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset state:
  - all entries free; reg_pend[31:0]=0; vec_pend[31:0]=0
  - inflight_o=0, idle_o=1, spurious_o=0
  - issue_ready_o is combinational; with the state cleared it is 1
- Per-entry state (SbLen entries): valid bit, rd_addr, rd_pend, vd_addr, vd_pend.
- Free-ID selection: lowest-indexed free entry, via a combinational priority encoder. issue_id_o shows that index every cycle.
- Hazard terms, all computed from registered state only:
  - RAW: any i with issue_rs_read_i[i] && rs_addr[i]!=0 && reg_pend[rs_addr[i]]; or any j with issue_vs_read_i[j] && vec_pend[vs_addr[j]]
  - WAW: rd_clobber && rd_addr!=0 && reg_pend[rd_addr]; or vd_clobber && vec_pend[vd_addr]
  - full: all entries valid
- issue_ready_o = !full && !RAW && !WAW. It does not depend on issue_valid_i.
- On issue fire (valid&&ready), at the next edge:
  - entry[id].valid=1
  - store rd/vd addresses and pend flags; rd_pend = rd_clobber && rd_addr!=0
  - set reg_pend[rd_addr] if rd_pend; set vec_pend[vd_addr] if vd_pend
- Scalar register x0 is never tracked. Vector register v0 is tracked like any other.
- On rsp_valid_i with entry[rsp_id_i].valid, at the next edge:
  - clear the entry valid bit
  - clear reg_pend/vec_pend for its stored addresses when its pend flags are set
  - responses may arrive in any order
- rsp_valid_i with an invalid entry: no state change; spurious_o=1 on the next cycle only.
- Issue and retire in the same cycle:
  - both take effect at the same edge
  - no bypass: the retiring entry's ID and pending bits are not usable by the issuing instruction until the following cycle (1-cycle stall)
  - the issue and retire IDs always differ, because the retiring entry is not free
- At most one pending writer per register (WAW stall), so clear operations never conflict.
- inflight_o: +1 on issue, -1 on valid retire, net 0 when both happen in the same cycle. Saturates logically at SbLen; the full stall guarantees it never exceeds SbLen.
- idle_o = (inflight_o==0).
- Reset mid-operation: all state clears asynchronously. Responses for pre-reset IDs that arrive after reset produce spurious_o.

Test Plan:
- Reset, then issue with rd=5, rd_clobber=1 -> issue_ready_o=1, issue_id_o=0; next cycle reg_pend[5]=1, inflight_o=1, idle_o=0.
- With x5 pending, offer rs_addr[0]=5 read -> issue_ready_o=0. Then rsp_valid_i with rsp_id_i=0 -> issue_ready_o=1 one cycle after the retire edge.
- vd=3 pending, offer vd=3 clobber (WAW) -> stalled. Offer instead vs[2]=4 read, vd=7 -> accepted with issue_id_o=1.
- Issue 16 instructions with no hazards -> IDs 0..15 in order, inflight_o=16, issue_ready_o=0. Retire ID 9 -> next issue gets issue_id_o=9.
- rd=0 with clobber and rs reads of x0 -> never stall, reg_pend unchanged. rsp_valid_i with an unallocated ID 12 -> spurious_o=1 for exactly one cycle, state unchanged.
- Same-cycle issue (ID 2) and retire (ID 0) -> inflight_o unchanged, both entries updated. Assert rst_i mid-run -> inflight_o=0 and all pending bits clear immediately (asynchronous).
